// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the signals between the calculator, the scan stage and
// the display pins.
//   disp0..disp3 : 5-bit display codes, digit 0 is the rightmost digit
//   ovf          : overflow flag, shown on the decimal point of digit 0
//   bright       : 4-bit brightness level (only with SEG_SCAN_DIM_EN)
//   seg          : segments, seg[0]=a .. seg[6]=g
//   dp           : decimal point
//   an           : anode enables, an[i] drives digit i
//   frame_tick   : one-cycle pulse after each shadow load
// Modports:
//   master : the producer side, which drives the codes and watches the display.
//   slave  : the scan stage itself.
// Optional feature macro: SEG_SCAN_DIM_EN adds the bright signal.
interface seg_scan_if;
  logic [4:0] disp0;
  logic [4:0] disp1;
  logic [4:0] disp2;
  logic [4:0] disp3;
  logic       ovf;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0] bright;
`endif
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

`ifdef SEG_SCAN_DIM_EN
  modport master (output disp0, disp1, disp2, disp3, ovf, bright,
                  input  seg, dp, an, frame_tick);
  modport slave  (input  disp0, disp1, disp2, disp3, ovf, bright,
                  output seg, dp, an, frame_tick);
`else
  modport master (output disp0, disp1, disp2, disp3, ovf,
                  input  seg, dp, an, frame_tick);
  modport slave  (input  disp0, disp1, disp2, disp3, ovf,
                  output seg, dp, an, frame_tick);
`endif
endinterface

// File: rtl/seg_scan.sv
// seg_scan: drives a 4-digit common-anode multiplexed 7-segment display from
// the calculator's four 5-bit display codes and its overflow flag.
// Each digit owns a slot of REFRESH_DIV cycles. The first BLANK_CYC cycles of
// every slot keep all anodes off, so the previous digit cannot ghost onto the
// next one. The codes are copied into a shadow set only at frame boundaries,
// which means a frame is never torn.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : seg_scan_if.slave (disp0..3 and ovf in; seg, dp, an, frame_tick out)
// Parameters:
//   REFRESH_DIV : cycles per digit slot (>= 2)
//   BLANK_CYC   : blank cycles at the start of each slot (< REFRESH_DIV)
//   ACTIVE_LOW  : 1 = seg/dp/an are asserted low, 0 = asserted high
// Optional feature macro: SEG_SCAN_DIM_EN adds PWM dimming of the anodes
// through bus.bright.
module seg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);

  localparam int SLOT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
  localparam logic [4:0]        CODE_BLANK = 5'd16;

  // Active-high segment patterns, bit order g..a.
  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'b0111111;
      5'd1:    decode = 7'b0000110;
      5'd2:    decode = 7'b1011011;
      5'd3:    decode = 7'b1001111;
      5'd4:    decode = 7'b1100110;
      5'd5:    decode = 7'b1101101;
      5'd6:    decode = 7'b1111101;
      5'd7:    decode = 7'b0000111;
      5'd8:    decode = 7'b1111111;
      5'd9:    decode = 7'b1101111;
      5'd10:   decode = 7'b1110111; // A
      5'd11:   decode = 7'b1010100; // n
      5'd12:   decode = 7'b0111001; // C
      5'd13:   decode = 7'b0111000; // L
      5'd14:   decode = 7'b0011100; // u
      5'd15:   decode = 7'b1110011; // P
      5'd16:   decode = 7'b0000000; // blank
      default: decode = 7'b1000000; // illegal codes show a dash
    endcase
  endfunction

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        idx;
  logic [4:0]        shadow [4];
  logic              shadow_ovf;
  logic              load_pend;
  logic              frame_tick_q;

  logic slot_end;
  logic load;

  assign slot_end = (slot_cnt == SLOT_LAST);
  // A load happens once right after reset, and then at every frame boundary.
  assign load = load_pend || (slot_end && (idx == 2'd3));

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] bright_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt     <= '0;
      idx          <= '0;
      load_pend    <= 1'b1;
      shadow_ovf   <= 1'b0;
      frame_tick_q <= 1'b0;
      // NOTE: the shadow codes are reset on purpose. The outputs decode straight
      // from them, so a reset must force a blank code for the display to go dark.
      for (int i = 0; i < 4; i++) shadow[i] <= CODE_BLANK;
`ifdef SEG_SCAN_DIM_EN
      pwm_cnt      <= '0;
      bright_q     <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments only, so every register
      // samples the pre-edge values of the others and ordering does not matter.
      slot_cnt     <= slot_end ? '0 : slot_cnt + 1'b1;
      frame_tick_q <= load;
      if (slot_end) idx <= idx + 2'd1;
      if (load) begin
        shadow[0]  <= bus.disp0;
        shadow[1]  <= bus.disp1;
        shadow[2]  <= bus.disp2;
        shadow[3]  <= bus.disp3;
        shadow_ovf <= bus.ovf;
        load_pend  <= 1'b0;
      end
`ifdef SEG_SCAN_DIM_EN
      pwm_cnt <= pwm_cnt + 4'd1;
      if (load) bright_q <= bus.bright;
`endif
    end
  end

  // Outputs come from registered state only. Internally everything is
  // active-high, and the polarity is applied once at the pins.
  logic [3:0] an_on;
  logic [6:0] seg_on;
  logic       dp_on;
  logic       active;

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block
    // can leave one unassigned and infer a latch.
    an_on  = '0;
    dp_on  = 1'b0;
    seg_on = decode(shadow[idx]);
    active = (slot_cnt >= BLANK_END);
    if (active) begin
`ifdef SEG_SCAN_DIM_EN
      an_on[idx] = (pwm_cnt < bright_q);
`else
      an_on[idx] = 1'b1;
`endif
      dp_on = (idx == 2'd0) && shadow_ovf;
    end
  end

  assign bus.an         = ACTIVE_LOW ? ~an_on  : an_on;
  assign bus.seg        = ACTIVE_LOW ? ~seg_on : seg_on;
  assign bus.dp         = ACTIVE_LOW ? ~dp_on  : dp_on;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with REFRESH_DIV=8,
// BLANK_CYC=2 and ACTIVE_LOW=1 (default build, no dimming).
// A table of display vectors is applied one frame at a time. Each vector
// pushes its four expected digit images into a scoreboard queue. Those are
// popped as the DUT lights each digit. Hand-written sequences cover reset,
// a mid-frame input change and a reset in the middle of a scan.
module tb_seg_scan;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seg_scan_if ifc ();

  seg_scan #(
    .REFRESH_DIV (8),
    .BLANK_CYC   (2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][4:0] code;  // code[d] drives digit d
    logic            ovf;
    logic [3:0][6:0] seg;   // expected active-low segments for digit d
    logic            dp0;   // expected active-low dp on digit 0
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  vec_t vecs [5];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    ifc.disp0 = v.code[0];
    ifc.disp1 = v.code[1];
    ifc.disp2 = v.code[2];
    ifc.disp3 = v.code[3];
    ifc.ovf   = v.ovf;
    for (int d = 0; d < 4; d++) begin
      e.an  = ~(4'b0001 << d);
      e.seg = v.seg[d];
      e.dp  = (d == 0) ? v.dp0 : 1'b1;
      sb.push_back(e);
    end
  endtask

  // Leave the current cycle, then stop on the next frame_tick.
  task automatic wait_frame();
    int n;
    n = 0;
    tick();
    while (!ifc.frame_tick && n < 40) begin
      tick();
      n++;
    end
    check("frame_tick_wait", 32'(ifc.frame_tick), 32'd1);
  endtask

  // Starts on a frame_tick cycle (slot 0 of digit 0) and walks one frame.
  task automatic observe_frame();
    int   blanks;
    int   act;
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      blanks = 0;
      while (ifc.an == 4'hf && blanks < 20) begin
        tick();
        blanks++;
      end
      check($sformatf("blank_len_d%0d", d), 32'(blanks), 32'd2);
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(sb.size()), 32'd1);
        return;
      end
      e = sb.pop_front();
      check($sformatf("an_d%0d", d), 32'(ifc.an), 32'(e.an));
      check($sformatf("seg_d%0d", d), 32'(ifc.seg), 32'(e.seg));
      check($sformatf("dp_d%0d", d), 32'(ifc.dp), 32'(e.dp));
      act = 0;
      while (ifc.an == e.an && act < 20) begin
        tick();
        act++;
      end
      check($sformatf("active_len_d%0d", d), 32'(act), 32'd6);
    end
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;

    // code[3..0]; segment images are active-low, g..a.
    vecs[0] = '{code: {5'd12, 5'd13, 5'd10, 5'd12}, ovf: 1'b0,
                seg: {7'b1000110, 7'b1000111, 7'b0001000, 7'b1000110}, dp0: 1'b1};
    vecs[1] = '{code: {5'd3, 5'd2, 5'd1, 5'd0}, ovf: 1'b1,
                seg: {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}, dp0: 1'b0};
    vecs[2] = '{code: {5'd7, 5'd6, 5'd5, 5'd4}, ovf: 1'b0,
                seg: {7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001}, dp0: 1'b1};
    vecs[3] = '{code: {5'd14, 5'd11, 5'd9, 5'd8}, ovf: 1'b0,
                seg: {7'b1100011, 7'b0101011, 7'b0010000, 7'b0000000}, dp0: 1'b1};
    vecs[4] = '{code: {5'd31, 5'd16, 5'd15, 5'd20}, ovf: 1'b1,
                seg: {7'b0111111, 7'b1111111, 7'b0001100, 7'b0111111}, dp0: 1'b0};

`ifdef SEG_SCAN_DIM_EN
    ifc.bright = 4'hf;
`endif

    // Reset held with random inputs: everything inactive.
    rst = 1'b0;
    ifc.disp0 = 5'($urandom);
    ifc.disp1 = 5'($urandom);
    ifc.disp2 = 5'($urandom);
    ifc.disp3 = 5'($urandom);
    ifc.ovf   = 1'($urandom);
    repeat (3) tick();
    check("rst_an", 32'(ifc.an), 32'hf);
    check("rst_seg", 32'(ifc.seg), 32'h7f);
    check("rst_dp", 32'(ifc.dp), 32'd1);
    check("rst_frame_tick", 32'(ifc.frame_tick), 32'd0);

    // Release: first load on the first edge, digit 0 lit at slot 2.
    rst = 1'b1;
    tick();
    check("rel_frame_tick", 32'(ifc.frame_tick), 32'd1);
    check("rel_an_blank", 32'(ifc.an), 32'hf);
    tick();
    check("rel_frame_tick_low", 32'(ifc.frame_tick), 32'd0);
    check("rel_an_d0", 32'(ifc.an), 32'he);

    // A frame lasts 4 slots of 8 cycles.
    wait_frame();
    n = 0;
    tick();
    n++;
    while (!ifc.frame_tick && n < 40) begin
      tick();
      n++;
    end
    check("frame_len", 32'(n), 32'd32);

    // Table vectors, one frame each, compared through the scoreboard.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i]);
      wait_frame();
      observe_frame();
    end

    // Mid-frame change of disp0 stays invisible until the next load.
    ifc.disp0 = 5'd1;
    ifc.ovf   = 1'b0;
    wait_frame();
    repeat (5) tick();
    ifc.disp0 = 5'd7;
    check("mid_an_old", 32'(ifc.an), 32'he);
    check("mid_seg_old", 32'(ifc.seg), 32'(7'b1111001));
    tick();
    check("mid_seg_old2", 32'(ifc.seg), 32'(7'b1111001));
    wait_frame();
    repeat (2) tick();
    check("mid_an_new", 32'(ifc.an), 32'he);
    check("mid_seg_new", 32'(ifc.seg), 32'(7'b1111000));
    check("mid_dp_new", 32'(ifc.dp), 32'd1);

    // Reset at idx=2, slot_cnt=5: outputs drop immediately, scan restarts.
    wait_frame();
    repeat (21) tick();
    check("mrst_pre_an", 32'(ifc.an), 32'hb);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_an", 32'(ifc.an), 32'hf);
    check("mrst_seg", 32'(ifc.seg), 32'h7f);
    check("mrst_dp", 32'(ifc.dp), 32'd1);
    check("mrst_frame_tick", 32'(ifc.frame_tick), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("mrst_rel_frame_tick", 32'(ifc.frame_tick), 32'd1);
    tick();
    check("mrst_rel_an_d0", 32'(ifc.an), 32'he);
    check("mrst_rel_seg", 32'(ifc.seg), 32'(7'b1111000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
